zap_mult_sequencer: RTL

Issue/retire sequencer placed directly upstream of the 32x32 multiplier. It accepts one multiply or multiply-accumulate request from the execute front end on a valid/ready handshake and latches the operands. It drives and holds them on the multiplier while the multiplier is busy, then captures the 32-bit result. It presents the result, the destination tag and optional N/Z flags to writeback on a second valid/ready handshake, and handles flush and reset while a multiply is in flight.

---
 rtl/zap_mult_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/zap_mult_sequencer.sv
// rtl/zap_mult_sequencer.sv - issue/retire sequencer in front of the 32x32 multiplier
//
// Accepts one MUL/MLA request on a valid/ready handshake and latches its operands.
// It issues a start pulse, holds the operands while the multiplier is busy, and captures
// the result. It then presents result, tag and flags to writeback on a second handshake.
// Optional feature macro: ZAP_MULT_FLAGS_EN (registered {N,Z} flags; tied to 0 otherwise).
//
// Ports:
//   i_clk, i_reset         clock (rising edge), asynchronous active-high reset
//   i_clear                pipeline flush, aborts any in-flight request
//   i_valid/o_ready        request handshake
//   i_rm/i_rs/i_rn         operands, result = rm*rs (+rn when i_accumulate)
//   i_accumulate, i_dest   MLA select, destination tag
//   o_mul_start/o_mul_clear        multiplier control
//   o_mul_rm/o_mul_rs/o_mul_rn     registered operands to multiplier
//   i_mul_rd, i_mul_busy           multiplier result and busy
//   o_valid/i_ready        result handshake to writeback
//   o_result, o_dest, o_flags      captured result, tag and {N,Z}

module zap_mult_sequencer #(
  parameter int DEST_WIDTH = 6
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_clear,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [31:0]           i_rm,
  input  logic [31:0]           i_rs,
  input  logic [31:0]           i_rn,
  input  logic                  i_accumulate,
  input  logic [DEST_WIDTH-1:0] i_dest,
  output logic                  o_mul_start,
  output logic                  o_mul_clear,
  output logic [31:0]           o_mul_rm,
  output logic [31:0]           o_mul_rs,
  output logic [31:0]           o_mul_rn,
  input  logic [31:0]           i_mul_rd,
  input  logic                  i_mul_busy,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [31:0]           o_result,
  output logic [DEST_WIDTH-1:0] o_dest,
  output logic [1:0]            o_flags
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_e;

  state_e                state_q, state_d;
  logic                  accept;
  logic                  capture;
  logic [31:0]           rm_q, rs_q, rn_q;
  logic [DEST_WIDTH-1:0] dest_q;
  logic [31:0]           result_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Flush wins over every other transition. A flush during ISSUE/WAIT cannot simply
  // return to IDLE: the multiplier may still be busy, so DRAIN waits it out.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    capture     = 1'b0;
    o_mul_start = 1'b0;
    o_mul_clear = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!i_clear && i_valid) begin
          accept  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (i_clear) begin
          o_mul_clear = 1'b1;
          state_d     = S_DRAIN;
        end else begin
          o_mul_start = 1'b1;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_clear) begin
          o_mul_clear = 1'b1;
          state_d     = S_DRAIN;
        end else if (!i_mul_busy) begin
          capture = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (i_clear || i_ready) begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (!i_mul_busy) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Accumulate is folded into rn at accept time; a MUL carries rn = 0.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rm_q     <= '0;
      rs_q     <= '0;
      rn_q     <= '0;
      dest_q   <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        rm_q   <= i_rm;
        rs_q   <= i_rs;
        rn_q   <= i_accumulate ? i_rn : 32'd0;
        dest_q <= i_dest;
      end
      if (capture) begin
        result_q <= i_mul_rd;
      end
    end
  end

`ifdef ZAP_MULT_FLAGS_EN
  logic [1:0] flags_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      flags_q <= 2'b00;
    end else if (capture) begin
      flags_q <= {i_mul_rd[31], (i_mul_rd == 32'd0)};
    end
  end

  assign o_flags = flags_q;
`else
  assign o_flags = 2'b00;
`endif

  // o_ready depends on state only, so i_ready never reaches it combinationally.
  assign o_ready  = (state_q == S_IDLE);
  assign o_valid  = (state_q == S_DONE);
  assign o_mul_rm = rm_q;
  assign o_mul_rs = rs_q;
  assign o_mul_rn = rn_q;
  assign o_result = result_q;
  assign o_dest   = dest_q;

endmodule
